// File: rtl/ram_pkg.sv
// Shared definitions for the dual-port RAM read and write engines:
// FSM encoding and the modulo-depth address increment.
package ram_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRun   = 2'd1,
      StDrain = 2'd2
   } state_e;

   // Next address with wrap at depth-1, so non-power-of-two depths work.
   function automatic int unsigned wrap_inc(input int unsigned addr, input int unsigned depth);
      return (addr == depth - 1) ? 0 : addr + 1;
   endfunction

endpackage

// File: rtl/ram_stream_reader_if.sv
// Request, RAM read port and output stream of the RAM stream reader.
// The master modport is the reader itself; slave is its environment.
interface ram_stream_reader_if #(
   parameter int unsigned DATAWIDTH = 32,
   parameter int unsigned DATADEPTH = 45
);
   localparam int unsigned AW = $clog2(DATADEPTH);

   logic                 start;
   logic [AW-1:0]        start_addr;
   logic [AW:0]          length;
   logic                 busy;
   logic                 done;
   logic                 err;
   logic [AW-1:0]        raddr;
   logic [DATAWIDTH-1:0] rdata_in;
   logic [DATAWIDTH-1:0] m_data;
   logic                 m_valid;
   logic                 m_ready;
   logic                 m_last;

   modport master (
      input  start, start_addr, length, rdata_in, m_ready,
      output busy, done, err, raddr, m_data, m_valid, m_last
   );

   modport slave (
      output start, start_addr, length, rdata_in, m_ready,
      input  busy, done, err, raddr, m_data, m_valid, m_last
   );

endinterface

// File: rtl/ram_addr_wrap.sv
// Combinational next-address unit, wrapping modulo DATADEPTH.
module ram_addr_wrap
   import ram_pkg::*;
#(
   parameter int unsigned DATADEPTH = 45,
   parameter int unsigned AW        = $clog2(DATADEPTH)
) (
   input  logic [AW-1:0] i_addr,
   output logic [AW-1:0] o_addr_next
);

   always_comb begin
      o_addr_next = AW'(wrap_inc(32'(i_addr), DATADEPTH));
   end

endmodule

// File: rtl/ram_stream_reader.sv
// Read-side engine: walks the RAM from a start address for a word count and
// streams the words out over valid/ready with a last marker.
module ram_stream_reader
   import ram_pkg::*;
#(
   parameter int unsigned DATAWIDTH = 32,
   parameter int unsigned DATADEPTH = 45
) (
   input  logic                i_rclk,
   input  logic                i_rrst,
   ram_stream_reader_if.master bus
);

   localparam int unsigned AW = $clog2(DATADEPTH);
   localparam logic [AW:0] DepthW = (AW+1)'(DATADEPTH);
   localparam logic [AW:0] RemOne = (AW+1)'(1);

   state_e               r_state;
   state_e               w_state_d;
   logic [AW-1:0]        r_raddr;
   logic [AW-1:0]        w_raddr_d;
   logic [AW-1:0]        w_raddr_inc;
   logic [AW:0]          r_remaining;
   logic [AW:0]          w_remaining_d;
   logic [DATAWIDTH-1:0] r_m_data;
   logic [DATAWIDTH-1:0] w_m_data_d;
   logic                 r_m_valid;
   logic                 w_m_valid_d;
   logic                 r_m_last;
   logic                 w_m_last_d;
   logic                 r_done;
   logic                 w_done_d;
   logic                 r_err;
   logic                 w_err_d;
   logic                 w_fetch;
   logic                 w_accept;
   logic                 w_bad_req;

   ram_addr_wrap #(
      .DATADEPTH (DATADEPTH),
      .AW        (AW)
   ) u_addr_wrap (
      .i_addr      (r_raddr),
      .o_addr_next (w_raddr_inc)
   );

   always_comb begin
      w_fetch   = (r_state == StRun) && (r_remaining != '0) && (!r_m_valid || bus.m_ready);
      w_accept  = r_m_valid && bus.m_ready;
      w_bad_req = ({1'b0, bus.start_addr} >= DepthW) || (bus.length > DepthW);
   end

   always_comb begin
      w_state_d     = r_state;
      w_raddr_d     = r_raddr;
      w_remaining_d = r_remaining;
      w_m_data_d    = r_m_data;
      w_m_valid_d   = r_m_valid;
      w_m_last_d    = r_m_last;
      w_done_d      = 1'b0;
      w_err_d       = 1'b0;

      unique case (r_state)
         StIdle: begin
            if (bus.start) begin
               if (w_bad_req) begin
                  w_err_d = 1'b1;
               end else if (bus.length == '0) begin
                  w_done_d = 1'b1;
               end else begin
                  w_raddr_d     = bus.start_addr;
                  w_remaining_d = bus.length;
                  w_state_d     = StRun;
               end
            end
         end
         StRun, StDrain: begin
            // A fetch never coincides with accepting the last word: once the
            // last word is out, remaining is already zero.
            if (w_fetch) begin
               w_m_data_d    = bus.rdata_in;
               w_m_valid_d   = 1'b1;
               w_m_last_d    = (r_remaining == RemOne);
               w_remaining_d = r_remaining - RemOne;
               w_raddr_d     = w_raddr_inc;
            end else if (w_accept) begin
               w_m_valid_d = 1'b0;
               w_m_last_d  = 1'b0;
            end

            if (w_accept && r_m_last) begin
               w_done_d  = 1'b1;
               w_state_d = StIdle;
            end else if ((r_state == StRun) && (r_remaining == '0)) begin
               w_state_d = StDrain;
            end
         end
         default: begin
            w_state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge i_rclk) begin
      if (i_rrst) begin
         r_state     <= StIdle;
         r_raddr     <= '0;
         r_remaining <= '0;
         r_m_data    <= '0;
         r_m_valid   <= 1'b0;
         r_m_last    <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_state     <= w_state_d;
         r_raddr     <= w_raddr_d;
         r_remaining <= w_remaining_d;
         r_m_data    <= w_m_data_d;
         r_m_valid   <= w_m_valid_d;
         r_m_last    <= w_m_last_d;
         r_done      <= w_done_d;
         r_err       <= w_err_d;
      end
   end

   always_comb begin
      bus.busy    = (r_state != StIdle);
      bus.done    = r_done;
      bus.err     = r_err;
      bus.raddr   = r_raddr;
      bus.m_data  = r_m_data;
      bus.m_valid = r_m_valid;
      bus.m_last  = r_m_last;
   end

endmodule
